// File: rtl/razor_pkg.sv
// Shared types and parameter defaults for the razor timing-error recovery block.
package razor_pkg;

    // Recovery FSM states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        REPLAY = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH   = 3;
    localparam int DEF_STALL_CYCLES = 1;
    localparam int DEF_WINDOW       = 16;
    localparam int DEF_ERR_THRESH   = 4;

    // Stall down-counter width; covers STALL_CYCLES up to 15
    localparam int STALL_CNT_W = 4;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/err_rate_monitor.sv
// Error-rate monitor: counts accepted errors per fixed window and raises a
// sticky throttle request until a full window passes with no errors.
module err_rate_monitor
    import razor_pkg::*;
#(
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic clk,
    input  logic rst,
    input  logic err_accepted,
    output logic throttle_req
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(WINDOW + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0] THRESH   = EW'(ERR_THRESH);

    logic [WW-1:0] r_win_cnt;
    logic [EW-1:0] r_win_err;
    logic          r_throttle;

    logic          w_wrap;
    logic [EW-1:0] w_win_err_nxt;
    logic          w_set;
    logic          w_clr;

    // Next window error count; an error on the wrap cycle opens the new window at 1
    always_comb begin
        w_wrap = (r_win_cnt == WIN_LAST);
        if (w_wrap)
            w_win_err_nxt = EW'(err_accepted);
        else
            w_win_err_nxt = r_win_err + EW'(err_accepted);
        w_set = err_accepted && (w_win_err_nxt == THRESH);
        w_clr = w_wrap && (r_win_err == '0);
    end

    // Window counter, window error counter and sticky throttle (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_win_err  <= '0;
            r_throttle <= 1'b0;
        end else begin
            r_win_cnt <= w_wrap ? '0 : r_win_cnt + WW'(1);
            r_win_err <= w_win_err_nxt;
            if (w_set)
                r_throttle <= 1'b1;
            else if (w_clr)
                r_throttle <= 1'b0;
        end
    end

    assign throttle_req = r_throttle;

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor recovery controller: commits main-flop data in RUN; on a detected
// timing error it stalls upstream, flushes downstream once, and replays the
// shadow-latch value after STALL_CYCLES cycles. All outputs are registered.
module razor_recovery_ctrl
    import razor_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int ERR_THRESH   = DEF_ERR_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  err_in,
    input  logic [DATA_WIDTH-1:0] d_main,
    input  logic [DATA_WIDTH-1:0] d_shadow,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  valid_out,
    output logic                  stall,
    output logic                  flush,
    output logic                  throttle_req,
    output logic [7:0]            err_count
);

    localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(STALL_CYCLES - 1);

    state_t                   r_state;
    logic [DATA_WIDTH-1:0]    r_q;
    logic [DATA_WIDTH-1:0]    r_hold;
    logic                     r_valid;
    logic                     r_stall;
    logic                     r_flush;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;
    logic [7:0]               r_err_count;

    state_t                   w_state_nxt;
    logic [DATA_WIDTH-1:0]    w_q_nxt;
    logic [DATA_WIDTH-1:0]    w_hold_nxt;
    logic                     w_valid_nxt;
    logic                     w_stall_nxt;
    logic                     w_flush_nxt;
    logic [STALL_CNT_W-1:0]   w_cnt_nxt;
    logic                     w_err_acc;

    // Next state and next registered outputs; STALL and REPLAY ignore all data inputs
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_hold_nxt  = r_hold;
        w_cnt_nxt   = r_stall_cnt;
        w_valid_nxt = 1'b0;
        w_stall_nxt = 1'b0;
        w_flush_nxt = 1'b0;
        w_err_acc   = 1'b0;
        case (r_state)
            RUN: begin
                if (valid_in && err_in) begin
                    w_err_acc   = 1'b1;
                    w_hold_nxt  = d_shadow;
                    w_stall_nxt = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = STALL_LOAD;
                    w_state_nxt = STALL;
                end else if (valid_in) begin
                    w_q_nxt     = d_main;
                    w_valid_nxt = 1'b1;
                end
            end
            STALL: begin
                w_stall_nxt = 1'b1;
                if (r_stall_cnt == '0) begin
                    w_state_nxt = REPLAY;
                    w_q_nxt     = r_hold;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_stall_cnt - STALL_CNT_W'(1);
                end
            end
            REPLAY: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State and output registers; reset drops any pending replay
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_q         <= '0;
            r_hold      <= '0;
            r_valid     <= 1'b0;
            r_stall     <= 1'b0;
            r_flush     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_hold      <= w_hold_nxt;
            r_valid     <= w_valid_nxt;
            r_stall     <= w_stall_nxt;
            r_flush     <= w_flush_nxt;
            r_stall_cnt <= w_cnt_nxt;
        end
    end

    // Lifetime accepted-error counter, saturating at 255
    always_ff @(posedge clk) begin
        if (rst)
            r_err_count <= '0;
        else if (w_err_acc)
            r_err_count <= sat_inc8(r_err_count);
    end

    err_rate_monitor #(
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_rate (
        .clk          (clk),
        .rst          (rst),
        .err_accepted (w_err_acc),
        .throttle_req (throttle_req)
    );

    assign q_out     = r_q;
    assign valid_out = r_valid;
    assign stall     = r_stall;
    assign flush     = r_flush;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Bench for razor_recovery_ctrl with default parameters (STALL_CYCLES=1,
// WINDOW=16, ERR_THRESH=4, DATA_WIDTH=3).
module tb_razor_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_in = 1'b0;
    logic [2:0] d_main = '0;
    logic [2:0] d_shadow = '0;
    logic       valid_in = 1'b0;
    logic [2:0] q_out;
    logic       valid_out;
    logic       stall;
    logic       flush;
    logic       throttle_req;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       r, vin, ein;
        logic [2:0] dm, ds;
        logic [2:0] q;
        logic       vo, st, fl, th;
        logic [7:0] ec;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[13];

    // expectation state for generated sequences
    int         n_err;
    int         since;
    logic [2:0] q_exp;

    razor_recovery_ctrl #(
        .DATA_WIDTH   (3),
        .STALL_CYCLES (1),
        .WINDOW       (16),
        .ERR_THRESH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .err_in       (err_in),
        .d_main       (d_main),
        .d_shadow     (d_shadow),
        .valid_in     (valid_in),
        .q_out        (q_out),
        .valid_out    (valid_out),
        .stall        (stall),
        .flush        (flush),
        .throttle_req (throttle_req),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string tag, input bit r, input bit vin, input bit ein,
                                input int dm, input int ds, input int q, input bit vo,
                                input bit st, input bit fl, input bit th, input int ec);
        vec_t v;
        v.tag = tag; v.r = r; v.vin = vin; v.ein = ein;
        v.dm = 3'(dm); v.ds = 3'(ds); v.q = 3'(q);
        v.vo = vo; v.st = st; v.fl = fl; v.th = th; v.ec = 8'(ec);
        return v;
    endfunction

    // drive one cycle, queue its expectation, compare after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.r; valid_in = v.vin; err_in = v.ein;
        d_main = v.dm; d_shadow = v.ds;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (q_out !== e.q || valid_out !== e.vo || stall !== e.st || flush !== e.fl ||
            throttle_req !== e.th || err_count !== e.ec) begin
            failures++;
            $display("FAIL %s: got q=%0d vo=%0b st=%0b fl=%0b th=%0b ec=%0d want q=%0d vo=%0b st=%0b fl=%0b th=%0b ec=%0d",
                     e.tag, q_out, valid_out, stall, flush, throttle_req, err_count,
                     e.q, e.vo, e.st, e.fl, e.th, e.ec);
        end
    endtask

    task automatic do_reset(input string tag);
        apply(mk(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        n_err = 0; since = 100; q_exp = '0;
    endtask

    // one cycle of an error/idle stream; errors only issued when the FSM is back in RUN
    task automatic run_cycle(input string tag, input bit err, input bit th);
        bit vo, st, fl;
        if (err) begin
            n_err++; since = 0;
            vo = 0; st = 1; fl = 1;
        end else begin
            since++;
            fl = 0;
            if (since == 1) begin
                vo = 1; st = 1; q_exp = 3'd5;
            end else begin
                vo = 0; st = 0;
            end
        end
        apply(mk(tag, 0, err, err, 2, 5, int'(q_exp), vo, st, fl, th,
                 (n_err > 255) ? 255 : n_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                tag          r vin ein dm ds  q vo st fl th ec
        tbl[0]  = mk("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk("clean5",       0, 1, 0, 5, 0, 5, 1, 0, 0, 0, 0);
        tbl[2]  = mk("clean6",       0, 1, 0, 6, 0, 6, 1, 0, 0, 0, 0);
        tbl[3]  = mk("idle_hold",    0, 0, 0, 7, 0, 6, 0, 0, 0, 0, 0);
        tbl[4]  = mk("err_novalid",  0, 0, 1, 2, 1, 6, 0, 0, 0, 0, 0);
        tbl[5]  = mk("err_accept",   0, 1, 1, 3, 4, 6, 0, 1, 1, 0, 1);
        tbl[6]  = mk("stall_replay", 0, 1, 1, 1, 2, 4, 1, 1, 0, 0, 1);
        tbl[7]  = mk("replay_ret",   0, 1, 1, 7, 7, 4, 0, 0, 0, 0, 1);
        tbl[8]  = mk("clean2",       0, 1, 0, 2, 0, 2, 1, 0, 0, 0, 1);
        tbl[9]  = mk("err2",         0, 1, 1, 0, 5, 2, 0, 1, 1, 0, 2);
        tbl[10] = mk("rst_in_stall", 1, 1, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk("no_replay",    0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk("clean3",       0, 1, 0, 3, 0, 3, 1, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++)
            apply(tbl[i]);

        // throttle: 4 errors in window 0, 1 in window 1, none in window 2
        do_reset("thr_reset");
        for (int c = 0; c <= 50; c++) begin
            bit e;
            e = (c == 0 || c == 3 || c == 6 || c == 9 || c == 20);
            run_cycle($sformatf("throttle_c%0d", c), e, (c >= 9 && c <= 46));
        end

        // saturation: 300 accepted errors, one every three cycles
        do_reset("sat_reset");
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 3; j++) begin
                int c;
                c = 3 * k + j;
                run_cycle($sformatf("sat_c%0d", c), (j == 0), (c >= 9));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/razor_recovery_ctrl.md
RAZOR_RECOVERY_CTRL -- requirements
Module: razor_recovery_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, width of the stage data word.
REQ-002 SHALL have parameter STALL_CYCLES, default 1, range 1..15, cycles held in STALL before replay.
REQ-003 SHALL have parameter WINDOW, default 16, range 2..256, length in cycles of the error-rate window.
REQ-004 SHALL have parameter ERR_THRESH, default 4, range 1..WINDOW, number of accepted errors in one window that raises throttle_req.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port err_in  input  1  timing-error flag from the stage error detector, valid for the same cycle as d_main.
REQ-008 SHALL have port d_main  input  DATA_WIDTH  main-flop stage value; may be corrupt when err_in=1.
REQ-009 SHALL have port d_shadow  input  DATA_WIDTH  late-sampled shadow value; correct when err_in=1.
REQ-010 SHALL have port valid_in  input  1  d_main/d_shadow carry a stage result this cycle.
REQ-011 SHALL have port q_out  output  DATA_WIDTH  committed stage result.
REQ-012 SHALL have port valid_out  output  1  q_out holds a new committed result this cycle.
REQ-013 SHALL have port stall  output  1  upstream shall hold its state; high whenever state is not RUN.
REQ-014 SHALL have port flush  output  1  one-cycle pulse telling downstream to discard its in-flight bubble.
REQ-015 SHALL have port throttle_req  output  1  request to the clock controller to lower frequency.
REQ-016 SHALL have port err_count  output  8  saturating count of accepted errors.

Function
REQ-017 SHALL run a three-state FSM: RUN, STALL, REPLAY; all outputs SHALL be registered.
REQ-018 In RUN, valid_in=1 and err_in=0 SHALL give q_out<=d_main and valid_out<=1 on the next edge (latency 1).
REQ-019 In RUN, valid_in=0 SHALL give valid_out<=0 with q_out held.
REQ-020 In RUN, valid_in=1 and err_in=1 (an accepted error) SHALL, on the same edge, capture d_shadow into a hold register, set valid_out<=0, stall<=1 and flush<=1, and go to STALL.
REQ-021 err_in with valid_in=0 SHALL be ignored: no state change and no count.
REQ-022 flush SHALL be high for exactly the first STALL cycle.
REQ-023 In STALL, a down-counter loaded with STALL_CYCLES-1 SHALL decrement each cycle; at zero the FSM SHALL go to REPLAY.
REQ-024 In STALL, valid_in, err_in, d_main and d_shadow SHALL be ignored.
REQ-025 On entry to REPLAY the block SHALL drive q_out=hold and valid_out=1 for one cycle, with stall still high.
REQ-026 The FSM SHALL return from REPLAY to RUN on the next edge, with stall<=0 and valid_out<=0.
REQ-027 Inputs presented during the REPLAY cycle SHALL be ignored.
REQ-028 Error-to-replay latency SHALL be 1+STALL_CYCLES edges; each error costs exactly STALL_CYCLES+1 stall cycles.
REQ-029 err_count SHALL increment by 1 per accepted error and saturate at 255.
REQ-030 A free-running window counter SHALL count 0..WINDOW-1 and wrap; a window error counter SHALL count accepted errors and clear on wrap.
REQ-031 An error on the wrap cycle SHALL count into the new window, giving a count of 1.
REQ-032 throttle_req SHALL set on the edge where the window error count reaches ERR_THRESH.
REQ-033 Once set, throttle_req SHALL stay high until a complete window ends with zero accepted errors, and SHALL clear on that wrap edge.
REQ-034 If set and clear conditions coincide, set SHALL win.

Reset
REQ-035 rst=1 SHALL, at the next edge, force state RUN, q_out=0, valid_out=0, stall=0, flush=0, throttle_req=0 and err_count=0.
REQ-036 rst=1 SHALL also clear the hold register, stall counter, window counter and window error counter.
REQ-037 rst SHALL override all other inputs, including mid-STALL or mid-REPLAY; the pending replay SHALL be discarded and no valid_out shall follow.

Structure
REQ-038 Shared package razor_pkg SHALL hold the FSM state enum (RUN, STALL, REPLAY) and the parameter defaults.
REQ-039 The window counter and throttle logic SHALL be one sub-module, err_rate_monitor, with inputs clk, rst and err_accepted, and output throttle_req.

Verification
REQ-040 Clean stream: valid_in=1, err_in=0, d_main=5 then 6 -> q_out=5 then 6 one edge later, valid_out=1, stall=0, err_count=0.
REQ-041 Single error, STALL_CYCLES=1: d_main=3, d_shadow=4, err_in=1 -> stall=1 and flush=1 for 1 cycle, then q_out=4 with valid_out=1 and stall=1, then stall=0; err_count=1.
REQ-042 Ignored error: err_in=1 with valid_in=0 -> no stall, no flush, err_count=0; err_in=1 during STALL -> not counted.
REQ-043 Throttle: WINDOW=16, ERR_THRESH=4, four accepted errors inside one window -> throttle_req=1 on the 4th error edge; it stays high through the next window with 1 error, and clears at the end of the following window with 0 errors.
REQ-044 Reset mid-operation: assert rst during the STALL cycle -> next edge state=RUN, stall=0, valid_out=0, err_count=0, no replay.
REQ-045 Saturation: 300 accepted errors -> err_count=255.
